// File: rtl/lbp_pkg.sv
// Shared types and default geometry for the LBP window-scan controller.
package lbp_pkg;

  localparam int LBP_IMG_W  = 128;
  localparam int LBP_IMG_H  = 128;
  localparam int LBP_ADDR_W = 14;

  // Serpentine direction of the current row: 1 walks right, 0 walks left.
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_OUT,
    S_MOVE_R,
    S_MOVE_D,
    S_MOVE_L,
    S_DONE
  } state_t;

endpackage

// File: rtl/lbp_scan_ctrl_if.sv
// Bus between the scan controller (master) and the image memory / LBP writer (slave).
interface lbp_scan_ctrl_if #(
  parameter int ADDR_W = lbp_pkg::LBP_ADDR_W
) ();
  import lbp_pkg::*;

  // gray_ready is a level start request sampled only in IDLE; gray_req marks a
  // fetch whose data returns in the same cycle, lbp_valid a one-cycle result write.
  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic              initialize;
  logic              right;
  logic              down;
  logic              left;
  logic [3:0]        cycle;
  logic [ADDR_W-1:0] lbp_addr;
  logic              lbp_valid;
  logic              finish;
  state_t            dbg_state;

  modport master (
    input  gray_ready,
    output gray_req, gray_addr, initialize, right, down, left, cycle,
    output lbp_addr, lbp_valid, finish, dbg_state
  );

  modport slave (
    output gray_ready,
    input  gray_req, gray_addr, initialize, right, down, left, cycle,
    input  lbp_addr, lbp_valid, finish, dbg_state
  );
endinterface

// File: rtl/lbp_coord_ctr.sv
// Centre row/col and serpentine direction of the 3x3 window; updated when a load completes.
module lbp_coord_ctr
  import lbp_pkg::*;
#(
  parameter int ADDR_W = LBP_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_init,
  input  logic              i_mv_r,
  input  logic              i_mv_d,
  input  logic              i_mv_l,
  output logic [ADDR_W-1:0] o_row,
  output logic [ADDR_W-1:0] o_col,
  output logic              o_dir
);

  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_col;
  logic              r_dir;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row <= '0;
      r_col <= '0;
      r_dir <= 1'b0;
    end else if (i_init) begin
      r_row <= ADDR_W'(1);
      r_col <= ADDR_W'(1);
      r_dir <= DIR_RIGHT;
    end else if (i_mv_r) begin
      r_col <= r_col + ADDR_W'(1);
    end else if (i_mv_l) begin
      r_col <= r_col - ADDR_W'(1);
    end else if (i_mv_d) begin
      r_row <= r_row + ADDR_W'(1);
      r_dir <= ~r_dir;
    end
  end

  assign o_row = r_row;
  assign o_col = r_col;
  assign o_dir = r_dir;

endmodule

// File: rtl/lbp_scan_ctrl.sv
// Serpentine 3x3 window scan over a grayscale image: fetches new pixels and
// strobes one LBP result per centre pixel.
module lbp_scan_ctrl
  import lbp_pkg::*;
#(
  parameter int IMG_W  = LBP_IMG_W,
  parameter int IMG_H  = LBP_IMG_H,
  parameter int ADDR_W = LBP_ADDR_W
) (
  input logic             clk,
  input logic             reset,
  lbp_scan_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] W_A       = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] END_COL_R = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] END_COL_L = ADDR_W'(1);

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              w_init_done, w_mv_r_done, w_mv_d_done, w_mv_l_done;
  logic [ADDR_W-1:0] w_row, w_col;
  logic              w_dir, w_at_end, w_fetch;
  logic [3:0]        w_init_row, w_init_col;
  logic [ADDR_W-1:0] w_off, w_row_sel, w_col_sel;

  lbp_coord_ctr #(.ADDR_W(ADDR_W)) u_coord (
    .clk    (clk),
    .reset  (reset),
    .i_init (w_init_done),
    .i_mv_r (w_mv_r_done),
    .i_mv_d (w_mv_d_done),
    .i_mv_l (w_mv_l_done),
    .o_row  (w_row),
    .o_col  (w_col),
    .o_dir  (w_dir)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_at_end = (w_dir == DIR_RIGHT) ? (w_col == END_COL_R) : (w_col == END_COL_L);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_init_done = 1'b0;
    w_mv_r_done = 1'b0;
    w_mv_d_done = 1'b0;
    w_mv_l_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.gray_ready) begin
          w_state_nxt = S_INIT;
          w_cnt_nxt   = 4'd1;
        end
      end
      S_INIT: begin
        if (r_cnt == 4'd9) begin
          w_state_nxt = S_OUT;
          w_cnt_nxt   = 4'd0;
          w_init_done = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_MOVE_R, S_MOVE_D, S_MOVE_L: begin
        if (r_cnt == 4'd3) begin
          w_state_nxt = S_OUT;
          w_cnt_nxt   = 4'd0;
          w_mv_r_done = (r_state == S_MOVE_R);
          w_mv_d_done = (r_state == S_MOVE_D);
          w_mv_l_done = (r_state == S_MOVE_L);
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_OUT: begin
        w_cnt_nxt = 4'd1;
        if (w_at_end && (w_row == LAST_ROW)) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = 4'd0;
        end else if (w_at_end) begin
          w_state_nxt = S_MOVE_D;
        end else if (w_dir == DIR_RIGHT) begin
          w_state_nxt = S_MOVE_R;
        end else begin
          w_state_nxt = S_MOVE_L;
        end
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Move fetches cover offsets -1..+1 along the new edge; r_cnt 1..3 maps to that.
  assign w_init_row = (r_cnt > 4'd6) ? 4'd2 : ((r_cnt > 4'd3) ? 4'd1 : 4'd0);
  assign w_init_col = r_cnt - 4'd1 - (4'd3 * w_init_row);
  assign w_off      = ADDR_W'(r_cnt);

  always_comb begin
    w_row_sel = '0;
    w_col_sel = '0;
    case (r_state)
      S_INIT: begin
        w_row_sel = ADDR_W'(w_init_row);
        w_col_sel = ADDR_W'(w_init_col);
      end
      S_MOVE_R: begin
        w_row_sel = w_row + w_off - ADDR_W'(2);
        w_col_sel = w_col + ADDR_W'(2);
      end
      S_MOVE_L: begin
        w_row_sel = w_row + w_off - ADDR_W'(2);
        w_col_sel = w_col - ADDR_W'(2);
      end
      S_MOVE_D: begin
        w_row_sel = w_row + ADDR_W'(2);
        w_col_sel = w_col + w_off - ADDR_W'(2);
      end
      default: begin
        w_row_sel = '0;
        w_col_sel = '0;
      end
    endcase
  end

  assign w_fetch = (r_state == S_INIT) || (r_state == S_MOVE_R) ||
                   (r_state == S_MOVE_D) || (r_state == S_MOVE_L);

  assign bus.gray_req   = w_fetch;
  assign bus.gray_addr  = w_fetch ? (w_row_sel * W_A + w_col_sel) : '0;
  assign bus.initialize = (r_state == S_INIT);
  assign bus.right      = (r_state == S_MOVE_R);
  assign bus.down       = (r_state == S_MOVE_D);
  assign bus.left       = (r_state == S_MOVE_L);
  assign bus.cycle      = w_fetch ? r_cnt : 4'd0;
  assign bus.lbp_valid  = (r_state == S_OUT);
  assign bus.lbp_addr   = (r_state == S_OUT) ? (w_row * W_A + w_col) : '0;
  assign bus.finish     = (r_state == S_DONE);
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Bench for lbp_scan_ctrl: a 128x128 and a 4x4 instance checked every cycle
// against an expected-output stream derived from the serpentine window walk.
module tb_lbp_scan_ctrl;
  import lbp_pkg::*;

  // {req, addr[13:0], init,right,down,left, cycle[3:0], valid, lbp_addr[13:0], finish}
  typedef logic [38:0] rec_t;
  typedef rec_t rec_q_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  lbp_scan_ctrl_if #(.ADDR_W(14)) bus_a ();
  lbp_scan_ctrl_if #(.ADDR_W(4))  bus_b ();

  lbp_scan_ctrl #(.IMG_W(128), .IMG_H(128), .ADDR_W(14)) dut_a (
    .clk(clk), .reset(rst_n), .bus(bus_a)
  );
  lbp_scan_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(4)) dut_b (
    .clk(clk), .reset(rst_n), .bus(bus_b)
  );

  rec_t act_a, act_b;
  assign act_a = {bus_a.gray_req, bus_a.gray_addr, bus_a.initialize, bus_a.right, bus_a.down,
                  bus_a.left, bus_a.cycle, bus_a.lbp_valid, bus_a.lbp_addr, bus_a.finish};
  assign act_b = {bus_b.gray_req, 10'b0, bus_b.gray_addr, bus_b.initialize, bus_b.right, bus_b.down,
                  bus_b.left, bus_b.cycle, bus_b.lbp_valid, 10'b0, bus_b.lbp_addr, bus_b.finish};

  function automatic rec_t mk(input bit req, input int addr, input logic [3:0] strb,
                              input int cyc, input bit valid, input int laddr, input bit fin);
    return {req, 14'(addr), strb, 4'(cyc), valid, 14'(laddr), fin};
  endfunction

  // Visit centres in serpentine order; each step fetches only the pixels newly
  // entering the window, then writes the centre.
  function automatic rec_q_t build_stream(input int w, input int h);
    rec_q_t q;
    int pr = 0, pc = 0, nr, nc;
    bit first = 1'b1;
    for (int rr = 1; rr <= h - 2; rr++) begin
      for (int k = 0; k < w - 2; k++) begin
        nr = rr;
        nc = (((rr - 1) % 2) == 0) ? (1 + k) : (w - 2 - k);
        if (first) begin
          for (int i = 0; i < 9; i++) q.push_back(mk(1, (i / 3) * w + (i % 3), 4'b1000, i + 1, 0, 0, 0));
          first = 1'b0;
        end else if (nr > pr) begin
          for (int j = 0; j < 3; j++) q.push_back(mk(1, (nr + 1) * w + nc - 1 + j, 4'b0010, j + 1, 0, 0, 0));
        end else if (nc > pc) begin
          for (int j = 0; j < 3; j++) q.push_back(mk(1, (nr - 1 + j) * w + nc + 1, 4'b0100, j + 1, 0, 0, 0));
        end else begin
          for (int j = 0; j < 3; j++) q.push_back(mk(1, (nr - 1 + j) * w + nc - 1, 4'b0001, j + 1, 0, 0, 0));
        end
        q.push_back(mk(0, 0, 4'b0000, 0, 1, nr * w + nc, 0));
        pr = nr;
        pc = nc;
      end
    end
    return q;
  endfunction

  task automatic compare_rec(input string name, input rec_t act, input rec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got req=%0b addr=%0d strb=%b cyc=%0d valid=%0b laddr=%0d fin=%0b, expected req=%0b addr=%0d strb=%b cyc=%0d valid=%0b laddr=%0d fin=%0b",
               name, act[38], act[37:24], act[23:20], act[19:16], act[15], act[14:1], act[0],
               exp[38], exp[37:24], exp[23:20], exp[19:16], exp[15], exp[14:1], exp[0]);
    end
  endtask

  task automatic compare_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model, one process per instance.
  int     ma_st = 0, mb_st = 0;
  rec_t   mq_a[$];
  rec_t   mq_b[$];

  always @(negedge clk) begin
    rec_t exp;
    exp = '0;
    if (!rst_n) begin
      ma_st = 0;
    end else if (ma_st == 0) begin
      if (bus_a.gray_ready) begin
        mq_a  = build_stream(128, 128);
        ma_st = 1;
      end
    end else if (ma_st == 1) begin
      exp = mq_a.pop_front();
      if (mq_a.size() == 0) ma_st = 2;
    end else begin
      exp = mk(0, 0, 4'b0000, 0, 0, 0, 1);
    end
    compare_rec("a_cycle", act_a, exp);
  end

  always @(negedge clk) begin
    rec_t exp;
    exp = '0;
    if (!rst_n) begin
      mb_st = 0;
    end else if (mb_st == 0) begin
      if (bus_b.gray_ready) begin
        mq_b  = build_stream(4, 4);
        mb_st = 1;
      end
    end else if (mb_st == 1) begin
      exp = mq_b.pop_front();
      if (mq_b.size() == 0) mb_st = 2;
    end else begin
      exp = mk(0, 0, 4'b0000, 0, 0, 0, 1);
    end
    compare_rec("b_cycle", act_b, exp);
  end

  // Whole-run statistics for the 128x128 instance.
  int va_cnt = 0, va_dup = 0, t_cyc = 0, t0 = -1, t_last = -1;
  bit seen_a[int];

  always @(negedge clk) begin
    t_cyc++;
    if (!rst_n) begin
      va_cnt = 0;
      va_dup = 0;
      seen_a.delete();
      t0     = -1;
      t_last = -1;
    end else begin
      if (bus_a.initialize && (bus_a.cycle == 4'd1)) t0 = t_cyc;
      if (bus_a.lbp_valid) begin
        va_cnt++;
        if (seen_a.exists(int'(bus_a.lbp_addr))) va_dup++;
        seen_a[int'(bus_a.lbp_addr)] = 1'b1;
        t_last = t_cyc;
      end
    end
  end

  initial begin
    rec_q_t q;
    int     init_addr[9] = '{0, 1, 2, 128, 129, 130, 256, 257, 258};
    int     turn_addr[6] = '{509, 510, 511, 252, 380, 508};
    int     b_laddr[4]   = '{5, 6, 10, 9};
    int     hits, n_hit;
    bit     done;

    bus_a.gray_ready = 1'b0;
    bus_b.gray_ready = 1'b0;
    rst_n            = 1'b0;

    // Hand-computed pins on the model itself.
    q = build_stream(128, 128);
    compare_int("model_len_128", q.size(), 63510);
    for (int i = 0; i < 9; i++) compare_rec("model_init", q[i], mk(1, init_addr[i], 4'b1000, i + 1, 0, 0, 0));
    compare_rec("model_out_129", q[9], mk(0, 0, 4'b0000, 0, 1, 129, 0));
    compare_rec("model_r1", q[10], mk(1, 3,   4'b0100, 1, 0, 0, 0));
    compare_rec("model_r2", q[11], mk(1, 131, 4'b0100, 2, 0, 0, 0));
    compare_rec("model_r3", q[12], mk(1, 259, 4'b0100, 3, 0, 0, 0));
    compare_rec("model_out_130", q[13], mk(0, 0, 4'b0000, 0, 1, 130, 0));
    for (int j = 0; j < 3; j++) compare_rec("model_turn_down", q[510 + j], mk(1, turn_addr[j], 4'b0010, j + 1, 0, 0, 0));
    compare_rec("model_out_382", q[513], mk(0, 0, 4'b0000, 0, 1, 382, 0));
    for (int j = 0; j < 3; j++) compare_rec("model_turn_left", q[514 + j], mk(1, turn_addr[3 + j], 4'b0001, j + 1, 0, 0, 0));
    compare_rec("model_out_381", q[517], mk(0, 0, 4'b0000, 0, 1, 381, 0));
    q = build_stream(4, 4);
    compare_int("model_len_4", q.size(), 22);
    for (int k = 0; k < 4; k++) compare_int("model_laddr_4", int'(q[9 + 4 * k][14:1]), b_laddr[k]);

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // 4x4 run with gray_ready randomly wiggling after the start.
    repeat ($urandom_range(1, 5)) @(posedge clk);
    #2 bus_b.gray_ready = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(posedge clk);
      #2 bus_b.gray_ready = 1'($urandom_range(0, 1));
      done = bus_b.finish;
    end
    compare_int("b_finish_reached", int'(done), 1);
    repeat (4) @(posedge clk);
    #2 bus_b.gray_ready = 1'b0;

    // Start the big image, then pull reset in the cycle-2 slot of a random right move.
    #0 bus_a.gray_ready = 1'b1;
    @(posedge clk);
    #2 bus_a.gray_ready = 1'b0;
    n_hit = $urandom_range(1, 20);
    hits  = 0;
    for (int c = 0; c < 200 && hits < n_hit; c++) begin
      @(negedge clk);
      if (bus_a.right && (bus_a.cycle == 4'd2)) hits++;
    end
    compare_int("a_reached_move_r", hits, n_hit);
    #1 rst_n = 1'b0;
    #1 compare_rec("a_async_reset", act_a, '0);
    compare_rec("b_async_reset", act_b, '0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Full run; gray_ready toggles randomly and must be ignored once scanning.
    repeat ($urandom_range(1, 6)) @(posedge clk);
    #2 bus_a.gray_ready = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 70000 && !done; c++) begin
      @(posedge clk);
      #2 bus_a.gray_ready = 1'($urandom_range(0, 1));
      done = bus_a.finish;
    end
    compare_int("a_finish_reached", int'(done), 1);
    compare_int("a_valid_count", va_cnt, 15876);
    compare_int("a_dup_addr", va_dup, 0);
    compare_int("a_scan_cycles", t_last - t0 + 1, 63510);
    repeat (5) @(posedge clk);
    #2 bus_a.gray_ready = 1'b0;
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
